// File: rtl/whack_game_engine.sv
// Whack-a-mole game core: phase sequencing, timers, mole placement
// and hit/miss scoring on a single clock driven by tick enables.

module whack_game_engine #(
  parameter int NUM_MOLES    = 16,
  parameter int GAME_SECONDS = 30,
  parameter int PREP_SECONDS = 3,
  parameter int LIFE_TICKS   = 8,
  parameter int PENALTY_EN   = 1,
  parameter int SCORE_MAX    = 9999
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic                 sec_tick_i,
  input  logic                 mole_tick_i,
  input  logic [NUM_MOLES-1:0] switches_i,
  output logic [NUM_MOLES-1:0] leds_o,
  output logic [13:0]          score_o,
  output logic [7:0]           time_left_o,
  output logic [1:0]           state_o,
  output logic                 hit_pulse_o,
  output logic                 miss_pulse_o
);

  localparam int IW = $clog2(NUM_MOLES);
  localparam int LW = $clog2(LIFE_TICKS) + 1;

  localparam logic [IW:0]   NM_W     = (IW+1)'(NUM_MOLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOLES - 1);
  localparam logic [13:0]   SMAX     = 14'(SCORE_MAX);
  localparam logic [7:0]    PREP_T   = 8'(PREP_SECONDS);
  localparam logic [7:0]    GAME_T   = 8'(GAME_SECONDS);
  localparam logic [NUM_MOLES-1:0] ONE = NUM_MOLES'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_PLAY = 2'b10,
    S_OVER = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           time_q, time_d;
  logic [13:0]          score_q, score_d;
  logic [NUM_MOLES-1:0] leds_q, leds_d;
  logic [LW-1:0]        life_q, life_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 last_vld_q, last_vld_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [NUM_MOLES-1:0] sw_prev_q;
  logic [NUM_MOLES-1:0] edge_q;
  logic [15:0]          lfsr_q;
  logic                 lfsr_fb;

  logic [IW:0]          raw_idx;
  logic [IW:0]          raw_sub;
  logic [IW-1:0]        base_idx;
  logic [IW-1:0]        spawn_idx;
  logic [NUM_MOLES-1:0] spawn_leds;
  logic [LW-1:0]        life_load;
  logic                 lit;
  logic                 hit;
  logic                 wrong;

  // x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2]
                 ^ lfsr_q[3] ^ lfsr_q[5];

  assign raw_idx = {1'b0, lfsr_q[IW-1:0]};
  assign raw_sub = raw_idx - NM_W;

  always_comb begin
    base_idx = raw_idx[IW-1:0];
    if (raw_idx >= NM_W) begin
      base_idx = raw_sub[IW-1:0];
    end
  end

  // Step past the previous position so a mole never reappears in place
  always_comb begin
    spawn_idx = base_idx;
    if (last_vld_q && base_idx == last_q) begin
      if (base_idx == LAST_IDX) begin
        spawn_idx = '0;
      end else begin
        spawn_idx = base_idx + IW'(1);
      end
    end
  end

  assign spawn_leds = ONE << spawn_idx;

  always_comb begin
    unique case (mode_q)
      2'b10:   life_load = LW'(LIFE_TICKS / 2);
      2'b11:   life_load = LW'(LIFE_TICKS / 4);
      default: life_load = LW'(LIFE_TICKS);
    endcase
  end

  assign lit   = |leds_q;
  assign hit   = |(edge_q & leds_q);
  assign wrong = (|edge_q) && !hit;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    time_d     = time_q;
    score_d    = score_q;
    leds_d     = leds_q;
    life_d     = life_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_i && mode_i != 2'b00) begin
          state_d    = S_PREP;
          mode_d     = mode_i;
          score_d    = '0;
          time_d     = PREP_T;
          leds_d     = '0;
          life_d     = '0;
          last_vld_d = 1'b0;
        end
      end

      S_PREP: begin
        if (sec_tick_i) begin
          if (time_q == 8'd1) begin
            state_d = S_PLAY;
            time_d  = GAME_T;
          end else begin
            time_d = time_q - 8'd1;
          end
        end
      end

      S_PLAY: begin
        if (hit) begin
          hit_d  = 1'b1;
          leds_d = '0;
          if (score_q < SMAX) begin
            score_d = score_q + 14'd1;
          end
        end else if (wrong) begin
          miss_d = 1'b1;
          if (PENALTY_EN != 0 && score_q != '0) begin
            score_d = score_q - 14'd1;
          end
        end

        // A hit on the expiry tick wins; the same tick never respawns
        if (mole_tick_i) begin
          if (!lit) begin
            leds_d     = spawn_leds;
            life_d     = life_load;
            last_d     = spawn_idx;
            last_vld_d = 1'b1;
          end else if (!hit) begin
            if (life_q == LW'(1)) begin
              leds_d = '0;
              life_d = '0;
              miss_d = 1'b1;
            end else begin
              life_d = life_q - LW'(1);
            end
          end
        end

        if (sec_tick_i) begin
          if (time_q == 8'd1) begin
            state_d = S_OVER;
            time_d  = '0;
            leds_d  = '0;
          end else begin
            time_d = time_q - 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      time_q     <= '0;
      score_q    <= '0;
      leds_q     <= '0;
      life_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      sw_prev_q  <= '0;
      edge_q     <= '0;
      lfsr_q     <= 16'hACE1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      time_q     <= time_d;
      score_q    <= score_d;
      leds_q     <= leds_d;
      life_q     <= life_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      sw_prev_q  <= switches_i;
      edge_q     <= switches_i & ~sw_prev_q;
      lfsr_q     <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  assign leds_o       = leds_q;
  assign score_o      = score_q;
  assign time_left_o  = time_q;
  assign state_o      = state_q;
  assign hit_pulse_o  = hit_q;
  assign miss_pulse_o = miss_q;

endmodule

// File: tb/tb_whack_game_engine.sv
// Randomised bench for whack_game_engine: game-level reference model
// feeding an expectation queue, drained by a negedge monitor.

module tb_whack_game_engine;

  localparam int N     = 5;
  localparam int GS    = 30;
  localparam int PS    = 3;
  localparam int LT    = 8;
  localparam int PEN   = 1;
  localparam int SMAX  = 12;
  localparam int IMASK = 7;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic         sec;
  logic         mtick;
  logic [N-1:0] sw;
  logic [N-1:0] leds;
  logic [13:0]  score;
  logic [7:0]   tleft;
  logic [1:0]   st;
  logic         hitp;
  logic         missp;

  whack_game_engine #(
    .NUM_MOLES   (N),
    .GAME_SECONDS(GS),
    .PREP_SECONDS(PS),
    .LIFE_TICKS  (LT),
    .PENALTY_EN  (PEN),
    .SCORE_MAX   (SMAX)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .sec_tick_i  (sec),
    .mole_tick_i (mtick),
    .switches_i  (sw),
    .leds_o      (leds),
    .score_o     (score),
    .time_left_o (tleft),
    .state_o     (st),
    .hit_pulse_o (hitp),
    .miss_pulse_o(missp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int tl;
    int sc;
    int leds;
    int hit;
    int miss;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  int m_ph, m_tl, m_sc, m_mole, m_life;
  int m_last, m_mode, m_prev, m_edge, m_lfsr;

  int mon_prev      = -1;
  int mon_last_leds = 0;
  int hold_win      = 0;
  int hold_hits     = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               name, got, want, $time);
    end
  endtask

  task automatic m_reset();
    m_ph   = 0;
    m_tl   = 0;
    m_sc   = 0;
    m_mole = -1;
    m_life = 0;
    m_last = -1;
    m_mode = 0;
    m_prev = 0;
    m_edge = 0;
    m_lfsr = 'hACE1;
  endtask

  // One clock of the game rules, using the inputs seen at this edge
  task automatic m_step();
    int   ed, h, ms, was_lit, idx, b;
    exp_t e;
    ed = m_edge;
    h  = 0;
    ms = 0;
    case (m_ph)
      0, 3: begin
        if (start === 1'b1 && mode != 2'b00) begin
          m_ph   = 1;
          m_mode = int'(mode);
          m_sc   = 0;
          m_tl   = PS;
          m_mole = -1;
          m_last = -1;
        end
      end
      1: begin
        if (sec === 1'b1) begin
          if (m_tl == 1) begin
            m_ph = 2;
            m_tl = GS;
          end else begin
            m_tl = m_tl - 1;
          end
        end
      end
      2: begin
        was_lit = (m_mole >= 0) ? 1 : 0;
        if (ed != 0) begin
          if (was_lit == 1 && ((ed >> m_mole) & 1) == 1) begin
            h      = 1;
            m_mole = -1;
            if (m_sc < SMAX) m_sc = m_sc + 1;
          end else begin
            ms = 1;
            if (PEN == 1 && m_sc > 0) m_sc = m_sc - 1;
          end
        end
        if (mtick === 1'b1) begin
          if (was_lit == 0) begin
            idx = m_lfsr & IMASK;
            if (idx >= N) idx = idx - N;
            if (idx == m_last) idx = (idx + 1) % N;
            m_mole = idx;
            m_last = idx;
            m_life = LT / (1 << (m_mode - 1));
          end else if (h == 0) begin
            m_life = m_life - 1;
            if (m_life == 0) begin
              m_mole = -1;
              ms     = 1;
            end
          end
        end
        if (sec === 1'b1) begin
          if (m_tl == 1) begin
            m_ph   = 3;
            m_tl   = 0;
            m_mole = -1;
          end else begin
            m_tl = m_tl - 1;
          end
        end
      end
      default: ;
    endcase
    m_edge = int'(sw) & ~m_prev & ((1 << N) - 1);
    m_prev = int'(sw);
    b = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3)
         ^ (m_lfsr >> 5)) & 1;
    m_lfsr = ((m_lfsr >> 1) | (b << 15)) & 'hFFFF;
    e.ph   = m_ph;
    e.tl   = m_tl;
    e.sc   = m_sc;
    e.leds = (m_mole < 0) ? 0 : (1 << m_mole);
    e.hit  = h;
    e.miss = ms;
    sbq.push_back(e);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_reset();
        sbq.delete();
      end else begin
        m_step();
      end
    end
  end

  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_last_leds = 0;
        mon_prev      = -1;
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("state", 32'(st), e.ph);
        chk("time_left", 32'(tleft), e.tl);
        chk("score", 32'(score), e.sc);
        chk("leds", 32'(leds), e.leds);
        chk("hit_pulse", 32'(hitp), e.hit);
        chk("miss_pulse", 32'(missp), e.miss);
        chk("leds_onehot", 32'($onehot0(leds)), 1);
        if (st == 2'b01) mon_prev = -1;
        if (leds != '0 && mon_last_leds == 0) begin
          idx = -1;
          for (int i = 0; i < N; i++)
            if (leds[i]) idx = i;
          if (mon_prev >= 0) begin
            checks++;
            if (idx == mon_prev) begin
              failures++;
              $display("FAIL no_repeat got=%0d prev=%0d t=%0t",
                       idx, mon_prev, $time);
            end
          end
          mon_prev = idx;
        end
        mon_last_leds = int'(leds);
        if (hold_win == 1 && hitp === 1'b1)
          hold_hits++;
      end
    end
  end

  task automatic drive(input logic s, input logic [1:0] m,
                       input logic sc, input logic mt,
                       input logic [N-1:0] w);
    @(posedge clk);
    #2;
    start = s;
    mode  = m;
    sec   = sc;
    mtick = mt;
    sw    = w;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(st), 0);
    chk({tag, "_time"}, 32'(tleft), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_leds"}, 32'(leds), 0);
    chk({tag, "_hit"}, 32'(hitp), 0);
    chk({tag, "_miss"}, 32'(missp), 0);
  endtask

  initial begin : main
    logic [N-1:0] w;
    int r;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    sec   = 1'b0;
    mtick = 1'b0;
    sw    = '0;
    w     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, '0);

    for (int c = 0; c < 12000; c++) begin
      r = int'($urandom % 8);
      case (r)
        0, 1, 2: w = '0;
        3, 4:    w = w | leds;
        5:       w[$urandom % N] = 1'b1;
        6:       w = w | N'($urandom);
        default: ;
      endcase
      drive(($urandom % 40) == 0, 2'($urandom % 4),
            ($urandom % 16) == 0, ($urandom % 4) == 0, w);
    end

    n = 0;
    while (st != 2'b10 && n < 200) begin
      drive(1'b1, 2'b10, n[0], 1'b0, '0);
      n++;
    end
    chk("reach_play", 32'(st), 2);
    for (int i = 0; i < 8; i++)
      drive(1'b0, 2'b00, 1'b0, i[0], '0);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    drive(1'b0, 2'b00, 1'b0, 1'b0, '1);
    drive(1'b1, 2'b01, 1'b0, 1'b0, '1);
    n = 0;
    while (st != 2'b10 && n < 50) begin
      drive(1'b0, 2'b00, 1'b1, 1'b0, '1);
      n++;
    end
    chk("reach_play_held", 32'(st), 2);
    hold_win = 1;
    for (int i = 0; i < 40; i++)
      drive(1'b0, 2'b11, 1'b0, i[0], '1);
    @(negedge clk);
    #1;
    hold_win = 0;
    chk("held_switch_no_hit", 32'(hold_hits), 0);

    repeat (3) drive(1'b0, 2'b00, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/whack_game_engine.md
Name: whack_game_engine

Overview:
- Parametrised single-clock game core for the whack-a-mole design: sequencing, timer, mole placement, hit/miss scoring and lit-mole output.
- Replaces per-mode derived clocks with tick-enable inputs, so everything runs on clock_i.
- Adds: configurable mole count, pre-game countdown, per-mole lifetime scaled by difficulty mode, wrong-switch penalty, no-repeat mole placement.
- Sits between the clock divider / mode selector (tick and mode sources) and the BCD/seven-segment display path (time_left_o / score_o).

Parameters:
- NUM_MOLES, 16, number of mole positions (LEDs/switches), 2..16.
- GAME_SECONDS, 30, play-phase duration in seconds, 1..255.
- PREP_SECONDS, 3, countdown before play, 1..255.
- LIFE_TICKS, 8, mole lifetime in mole ticks for mode 01, power of 2, >=4.
- PENALTY_EN, 1, 1 = wrong switch decrements score.
- SCORE_MAX, 9999, score saturation ceiling.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  single-cycle start pulse, debounced upstream.
- mode_i  in  2  difficulty; 00 none, 01 easy, 10 medium, 11 hard.
- sec_tick_i  in  1  one-cycle pulse at 1 Hz.
- mole_tick_i  in  1  one-cycle pulse at mole step rate.
- switches_i  in  NUM_MOLES  player switches, synchronised upstream.
- leds_o  out  NUM_MOLES  one-hot lit mole, or zero.
- score_o  out  14  current/final score.
- time_left_o  out  8  seconds remaining in PREP or PLAY.
- state_o  out  2  00 IDLE, 01 PREP, 10 PLAY, 11 OVER.
- hit_pulse_o  out  1  one-cycle pulse per hit.
- miss_pulse_o  out  1  one-cycle pulse per wrong switch or expiry.

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = 16'hACE1; switch edge registers = 0.
- LFSR: x^16+x^14+x^13+x^11+1, Fibonacci, advances every clock in every state.
- IDLE / OVER + start_i with mode_i != 00:
  - go to PREP; latch mode_i; score_o = 0; time_left_o = PREP_SECONDS; leds_o = 0.
  - start_i with mode_i = 00 is ignored.
- PREP: each sec_tick_i decrements time_left_o. On the tick where it would reach 0, go to PLAY with time_left_o = GAME_SECONDS. start_i is ignored.
- PLAY timer: each sec_tick_i decrements. On the tick when time_left_o = 1, go to OVER next cycle; time_left_o = 0 and leds_o cleared. score_o holds in OVER.
- Lifetime by latched mode: 01 = LIFE_TICKS, 10 = LIFE_TICKS/2, 11 = LIFE_TICKS/4.
- Spawn: in PLAY with leds_o = 0, a mole_tick_i lights a new mole and loads the life counter.
- Mole index:
  - idx = LFSR low bits; if idx >= NUM_MOLES, subtract NUM_MOLES.
  - If idx equals the previous mole index, use idx+1, wrapping to 0.
  - First mole of a game has no previous.
- Expiry: each mole_tick_i with a mole lit decrements life. At 0: clear leds_o, pulse miss_pulse_o, score unchanged. That same tick does not spawn.
- Switch edges: rising edges only (switches_i & ~prev). Edge registers update in all states, so a switch already high at PLAY entry never scores. Edges are evaluated only in PLAY.
- Any edge on the lit position:
  - hit; score +1, saturating at SCORE_MAX; hit_pulse_o.
  - leds_o cleared next cycle; next spawn on the following mole_tick_i.
- Else, any edge elsewhere (or with no mole lit):
  - one miss_pulse_o per cycle, regardless of edge count.
  - If PENALTY_EN, score -1, saturating at 0.
- Same-cycle events:
  - Hit and expiry tick: hit wins, no miss.
  - Hit and final sec_tick_i: hit scores, then OVER.
  - Hit on the lit mole plus a wrong edge: hit only.
  - sec_tick_i and mole_tick_i are independent and may coincide.
- mode_i changes after start are ignored until the next start.
- Asynchronous reset mid-game returns to IDLE immediately with all outputs 0.
- Latency: hit/miss pulse and score update 1 cycle after the registered edge; state_o changes 1 cycle after the causing tick.

Test Plan:
- Reset, mode_i=10, start_i pulse -> state_o=01, time_left_o=3; after 3 sec ticks: state_o=10, time_left_o=30, leds_o=0.
- PLAY, mode 01, raise switch at lit mole (e.g. leds_o=0x0010, switches_i bit 4) -> hit_pulse_o 1 cycle, score_o 0->1, leds_o=0 next cycle.
- PENALTY_EN=1, score_o=2, wrong switches 0 and 3 rise together -> one miss_pulse_o, score_o=1. At score_o=0, wrong edge -> score_o stays 0.
- Mode 11, LIFE_TICKS=8, no switch activity -> mole expires after 2 mole ticks with miss_pulse_o; 1000 spawns never repeat an index; NUM_MOLES=5 never lights bits >= 5.
- 30 sec ticks in PLAY with score 7 -> state_o=11, leds_o=0, score_o holds 7; start_i with mode_i=00 ignored; start_i with mode 01 -> PREP, score_o=0.
- Assert reset_i low mid-PLAY between clock edges -> outputs 0 and state_o=00 immediately; switch held high across a new PLAY entry -> no hit.
